sinc_dec_ctrl: RTL and testbench
================================

Name: sinc_dec_ctrl

Overview:
- Sequencing controller for the third-order sinc decimation filter that sits behind the delta-sigma modulator loop.
- Clears the filter, gates the integrator stage and generates the decimation strobe for the differentiator stage at a programmable oversampling ratio.
- Discards the unsettled start-up outputs.
- Buffers decimated samples in a small FIFO with a valid/ready output handshake toward the downstream consumer.

Parameters:
- DATA_W, 20, width of differentiator output and FIFO data.
- OSR_W, 8, width of the decimation phase counter and cfg_osr_m1.
- SETTLE_CNT, 3, number of decimated samples discarded after start (filter order).
- FIFO_DEPTH, 4, output buffer entries; must be a power of two and >= 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- en  in  1  run request; level-sensitive.
- cfg_osr_m1  in  OSR_W  decimation ratio minus 1; latched on the IDLE->FLUSH transition.
- ovf_clr  in  1  clears sticky overflow.
- filt_clr  out  1  synchronous clear to integrators, differentiators and the filter count.
- integ_en  out  1  integrator stage enable.
- dec_stb  out  1  one-cycle differentiator update strobe.
- dif_data  in  DATA_W  differentiator (comb) output; valid the cycle after dec_stb.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_W  FIFO head.
- busy  out  1  state != IDLE.
- settled  out  1  state == RUN.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.

Behaviour:
- Reset (RST=0, async) forces:
  - state to IDLE;
  - phase counter, settle counter, osr_lat and FIFO pointers to 0;
  - all outputs to 0 (out_data reads 0).
- States:
  - IDLE: integ_en=0, dec_stb=0, phase held at 0.
    - en=1 -> FLUSH; latch osr_lat = max(cfg_osr_m1, 1), so OSR 1 is illegal and is coerced to 2.
    - Also clear the settle counter and overflow.
  - FLUSH: exactly one cycle with filt_clr=1; integ_en=0.
    - -> SETTLE if en=1, else -> IDLE.
  - SETTLE: integ_en=1; phase increments every cycle and wraps at osr_lat.
    - dec_stb=1 in the cycle where phase==osr_lat.
    - cap_stb is dec_stb delayed one cycle.
    - Each cap_stb increments the settle counter; dif_data is discarded.
    - The capture that brings the counter to SETTLE_CNT moves state to RUN on the same edge.
    - That sample is also discarded.
  - RUN: same phase/strobe behaviour as SETTLE; each cap_stb pushes dif_data into the FIFO.
  - Any non-IDLE state with en=0: next state IDLE; integ_en drops the next cycle.
    - A pending cap_stb in flight is dropped.
    - FIFO contents are retained and remain drainable in IDLE.
- The phase counter does not reset on SETTLE->RUN, so strobes are periodic from the first SETTLE cycle.
  - First dec_stb occurs in SETTLE cycle osr_lat+1, counting the first SETTLE cycle as cycle 1.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push is accepted when not full, or when full with a simultaneous pop.
  - Otherwise the sample is dropped and overflow sets.
  - Push and pop on empty: the sample is written and becomes visible the next cycle; out_valid is registered and there is no bypass.
  - out_data is stable while out_valid && !out_ready.
- overflow: set on drop, cleared by ovf_clr or by IDLE->FLUSH. If set and clear occur in the same cycle, set wins.
- Changes to cfg_osr_m1 while busy are ignored until the next IDLE->FLUSH.
- Arithmetic: phase is unsigned OSR_W bits. FIFO pointers are log2(FIFO_DEPTH)+1 bits, with full/empty decoded from the MSB.

Optional Feature:
- Macro SINC_DEC_CTRL_SEQ_EN.
- Defined:
  - Adds output port out_seq[7:0].
  - An 8-bit sequence counter increments on every accepted push and wraps 255->0.
  - The counter is stored in the FIFO alongside the data.
  - It resets to 0 on IDLE->FLUSH.
  - Dropped samples still increment it, so the consumer can detect gaps.
- Undefined: no port, no counter, FIFO width is DATA_W.

Decomposition:
- Package sinc_dec_ctrl_pkg holds:
  - state enum {IDLE, FLUSH, SETTLE, RUN} (2 bits);
  - default localparams DATA_W_DEF=20, OSR_W_DEF=8, SETTLE_CNT_DEF=3.
- Sub-module sinc_dec_fifo: parameterised synchronous FIFO (width, depth) with push/pop/full/empty. The controller FSM, phase and settle logic stay in the top.

Test Plan:
- Reset and start: RST low mid-RUN with out_valid=1 -> all outputs 0 immediately (async), FIFO empty after release.
- OSR and settle: en=1, cfg_osr_m1=15, dif_data=cycle count, out_ready=1.
  - filt_clr high exactly 1 cycle.
  - dec_stb every 16 cycles.
  - The first 3 captures are discarded; settled rises at the 3rd capture.
  - The first out_valid carries the 4th capture's dif_data.
- Coercion: cfg_osr_m1=0 -> dec_stb period 2 cycles. Changing cfg_osr_m1 to 7 mid-RUN leaves the period unchanged.
- Overflow: cfg_osr_m1=1, out_ready=0 in RUN.
  - 4 samples stored; the 5th is dropped and overflow=1.
  - out_data still equals the first stored sample.
  - Then out_ready=1 drains 4 samples in order.
  - ovf_clr pulse -> overflow=0.
- Full with simultaneous push/pop: FIFO full, out_ready=1 on the cap_stb cycle -> no drop, overflow stays 0, count stays 4.
- en drop: en=0 mid-SETTLE -> IDLE next cycle, integ_en=0, no push. Re-assert en -> new FLUSH, settle restarts at 0. With SINC_DEC_CTRL_SEQ_EN, out_seq restarts at 0.

Source files
------------

// File: rtl/sinc_dec_ctrl_pkg.sv
// Shared state encoding and default parameter values for the sinc decimator controller.
package sinc_dec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_e;

    localparam int DATA_W_DEF     = 20;
    localparam int OSR_W_DEF      = 8;
    localparam int SETTLE_CNT_DEF = 3;

endpackage

// File: rtl/sinc_dec_fifo.sv
// Synchronous FIFO, registered empty/full, no write-to-read bypass; full accepts a push only alongside a pop.
// Head data reads 0 while empty so the output is clean straight out of reset.
module sinc_dec_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok, push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/sinc_dec_ctrl.sv
// Sinc3 decimator sequencer: filter clear, integrator gate, decimation strobe, settle discard, output FIFO.
// Define SINC_DEC_CTRL_SEQ_EN to add out_seq, an 8-bit sample sequence number stored with each FIFO entry.
module sinc_dec_ctrl
    import sinc_dec_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int OSR_W      = OSR_W_DEF,
    parameter int SETTLE_CNT = SETTLE_CNT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic [OSR_W-1:0]  cfg_osr_m1,
    input  logic              ovf_clr,
    output logic              filt_clr,
    output logic              integ_en,
    output logic              dec_stb,
    input  logic [DATA_W-1:0] dif_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              settled,
    output logic              overflow
`ifdef SINC_DEC_CTRL_SEQ_EN
    ,
    output logic [7:0]        out_seq
`endif
);
    localparam int SET_W = $clog2(SETTLE_CNT + 1);
`ifdef SINC_DEC_CTRL_SEQ_EN
    localparam int FIFO_W = DATA_W + 8;
`else
    localparam int FIFO_W = DATA_W;
`endif

    logic [1:0]        state_q, state_d;
    logic [OSR_W-1:0]  phase_q, phase_d;
    logic [OSR_W-1:0]  osr_lat_q, osr_lat_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              cap_stb_q;
    logic              ovf_q;
    logic              active, start, capture, push, drop;
    logic              fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

    assign active  = (state_q == SETTLE) || (state_q == RUN);
    assign start   = (state_q == IDLE) && en;
    // A capture only counts while still enabled; one in flight when en drops is lost.
    assign capture = active && en && cap_stb_q;
    assign push    = capture && (state_q == RUN);
    assign drop    = push && fifo_full && !out_ready;

    assign filt_clr  = (state_q == FLUSH);
    assign integ_en  = active;
    assign dec_stb   = active && (phase_q == osr_lat_q);
    assign busy      = (state_q != IDLE);
    assign settled   = (state_q == RUN);
    assign overflow  = ovf_q;
    assign out_valid = !fifo_empty;

    always_comb begin
        state_d   = state_q;
        osr_lat_d = osr_lat_q;
        settle_d  = settle_q;
        phase_d   = '0;
        if (active && en) phase_d = dec_stb ? '0 : phase_q + 1'b1;
        case (state_q)
            IDLE: if (en) begin
                state_d   = FLUSH;
                osr_lat_d = (cfg_osr_m1 == '0) ? OSR_W'(1) : cfg_osr_m1;
                settle_d  = '0;
            end
            FLUSH: state_d = en ? SETTLE : IDLE;
            SETTLE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (cap_stb_q) begin
                    settle_d = settle_q + 1'b1;
                    if (settle_q + 1'b1 == SET_W'(SETTLE_CNT)) state_d = RUN;
                end
            end
            RUN: if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            osr_lat_q <= '0;
            settle_q  <= '0;
            cap_stb_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            osr_lat_q <= osr_lat_d;
            settle_q  <= settle_d;
            cap_stb_q <= dec_stb;
            if (drop) ovf_q <= 1'b1;
            else if (ovf_clr || start) ovf_q <= 1'b0;
        end
    end

`ifdef SINC_DEC_CTRL_SEQ_EN
    // Advances on dropped samples too so the consumer sees the gap.
    logic [7:0] seq_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) seq_q <= '0;
        else if (start) seq_q <= '0;
        else if (push) seq_q <= seq_q + 8'd1;
    end
    assign fifo_wdata = {seq_q, dif_data};
    assign out_seq    = fifo_rdata[FIFO_W-1:DATA_W];
`else
    assign fifo_wdata = dif_data;
`endif
    assign out_data = fifo_rdata[DATA_W-1:0];

    sinc_dec_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (out_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (fifo_rdata)
    );

endmodule

// File: tb/tb_sinc_dec_ctrl.sv
// Randomised and directed bench for sinc_dec_ctrl against a cycle-count reference model.
module tb_sinc_dec_ctrl;
    localparam int DW     = 20;
    localparam int SETTLE = 3;
    localparam int DEPTH  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          en = 1'b0, ovf_clr = 1'b0, out_ready = 1'b0;
    logic [7:0]    cfg_osr_m1 = 8'd0;
    logic [DW-1:0] dif_data = '0;
    logic          filt_clr, integ_en, dec_stb, out_valid, busy, settled, overflow;
    logic [DW-1:0] out_data;
`ifdef SINC_DEC_CTRL_SEQ_EN
    logic [7:0]    out_seq;
`endif

    sinc_dec_ctrl dut (
        .CLK(CLK), .RST(RST), .en(en), .cfg_osr_m1(cfg_osr_m1), .ovf_clr(ovf_clr),
        .filt_clr(filt_clr), .integ_en(integ_en), .dec_stb(dec_stb), .dif_data(dif_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .settled(settled), .overflow(overflow)
`ifdef SINC_DEC_CTRL_SEQ_EN
        , .out_seq(out_seq)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit dif_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: mode 0=idle 1=flush 2=active; k counts active cycles from 1, strobe when k is a multiple of the period.
    int            m_mode, m_k, m_caps, m_P;
    bit            m_cap, m_ovf;
    logic [DW-1:0] m_q[$];
    logic [7:0]    m_sq[$];
    logic [7:0]    m_seq;

    function automatic bit m_dec();
        return (m_mode == 2) && ((m_k % m_P) == 0);
    endfunction

    task automatic m_reset();
        m_mode = 0; m_k = 0; m_caps = 0; m_P = 2; m_cap = 0; m_ovf = 0; m_seq = 0;
        m_q.delete(); m_sq.delete();
    endtask

    task automatic m_edge();
        bit dec_pre, pop, drop;
        int sz;
        dec_pre = m_dec();
        sz = m_q.size();
        pop = (sz > 0) && out_ready;
        drop = 0;
        if (pop) begin m_q.delete(0); m_sq.delete(0); end
        if (m_cap && m_mode == 2 && en) begin
            if (m_caps < SETTLE) m_caps++;
            else begin
                if (sz < DEPTH || pop) begin m_q.push_back(dif_data); m_sq.push_back(m_seq); end
                else drop = 1;
                m_seq++;
            end
        end
        if (drop) m_ovf = 1;
        else if (ovf_clr || (m_mode == 0 && en)) m_ovf = 0;
        m_cap = (m_mode == 2) && dec_pre;
        case (m_mode)
            0: if (en) begin
                m_mode = 1; m_caps = 0; m_seq = 0;
                m_P = ((cfg_osr_m1 == 0) ? 1 : int'(cfg_osr_m1)) + 1;
            end
            1: if (en) begin m_mode = 2; m_k = 1; end else m_mode = 0;
            default: if (en) m_k++; else m_mode = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        m_edge();
        cyc++;
        #1;
        chk("filt_clr",  32'(filt_clr),  32'(m_mode == 1));
        chk("integ_en",  32'(integ_en),  32'(m_mode == 2));
        chk("dec_stb",   32'(dec_stb),   32'(m_dec()));
        chk("busy",      32'(busy),      32'(m_mode != 0));
        chk("settled",   32'(settled),   32'(m_mode == 2 && m_caps >= SETTLE));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("out_data",  32'(out_data),  32'((m_q.size() > 0) ? m_q[0] : '0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
`ifdef SINC_DEC_CTRL_SEQ_EN
        chk("out_seq",   32'(out_seq),   32'((m_sq.size() > 0) ? m_sq[0] : 8'd0));
`endif
        dif_data = dif_cnt ? DW'(cyc) : DW'($urandom);
    endtask

    task automatic meas_period(output int p);
        int first;
        first = -1;
        p = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (dec_stb) begin
                if (first < 0) first = i;
                else begin p = i - first; break; end
            end
        end
    endtask

    initial begin
        int n, t1, t2, s, v, p, hits;
        m_reset();
        #1;
        chk("rst_filt_clr", 32'(filt_clr), 0);
        chk("rst_integ_en", 32'(integ_en), 0);
        chk("rst_dec_stb",  32'(dec_stb),  0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_overflow", 32'(overflow), 0);
        #11 RST = 1'b1;
        tick(); tick();

        // OSR 16, sample data = cycle count
        dif_cnt = 1; out_ready = 1; cfg_osr_m1 = 8'd15; en = 1;
        n = 0; t1 = -1; t2 = -1; s = -1; v = -1;
        while (n < 300 && v < 0) begin
            tick(); n++;
            if (dec_stb) begin if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n; end
            if (settled && s < 0) s = n;
            if (out_valid) v = n;
        end
        chk("first_dec", 32'(t1), 17);
        chk("dec_period16", 32'(t2 - t1), 16);
        chk("settle_at", 32'(s), 51);
        chk("first_valid", 32'(v), 67);
        repeat (40) tick();
        en = 0; tick(); tick();

        // OSR coercion and mid-run cfg change
        dif_cnt = 0; cfg_osr_m1 = 8'd0; en = 1;
        repeat (10) tick();
        meas_period(p);
        chk("osr_coerce", 32'(p), 2);
        cfg_osr_m1 = 8'd7;
        repeat (5) tick();
        meas_period(p);
        chk("osr_midrun", 32'(p), 2);
        en = 0; tick();
        repeat (6) tick();

        // Overflow with consumer stalled
        cfg_osr_m1 = 8'd1; out_ready = 0; en = 1;
        n = 0;
        while (n < 200 && !overflow) begin tick(); n++; end
        chk("ovf_set", 32'(overflow), 1);
        en = 0; out_ready = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) n++;
            tick();
        end
        chk("drain_cnt", 32'(n), 4);
        chk("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1; tick(); ovf_clr = 0;
        chk("ovf_clr", 32'(overflow), 0);

        // Full FIFO with push and pop on the same edge
        out_ready = 0; en = 1; hits = 0;
        for (int i = 0; i < 80; i++) begin
            out_ready = (m_cap && m_mode == 2 && m_caps >= SETTLE && m_q.size() == DEPTH);
            tick();
            if (out_ready) begin
                hits++;
                chk("full_pp_ovf", 32'(overflow), 0);
                chk("full_pp_valid", 32'(out_valid), 1);
            end
        end
        chk("full_pp_hits", 32'(hits >= 3), 1);
        en = 0; out_ready = 1; tick();
        repeat (6) tick();

        // en drop mid-SETTLE, then restart
        cfg_osr_m1 = 8'd3; en = 1;
        repeat (8) tick();
        en = 0; tick();
        chk("endrop_busy", 32'(busy), 0);
        chk("endrop_integ", 32'(integ_en), 0);
        repeat (3) begin tick(); chk("endrop_nopush", 32'(out_valid), 0); end
        en = 1; n = 0;
        while (n < 100 && !settled) begin tick(); n++; end
        chk("resettle", 32'(n), 15);
        n = 0;
        while (n < 100 && !out_valid) begin tick(); n++; end
`ifdef SINC_DEC_CTRL_SEQ_EN
        chk("seq_restart", 32'(out_seq), 0);
`endif
        chk("restart_valid", 32'(out_valid), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                en = ~en;
                if (en) cfg_osr_m1 = 8'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 199) == 0) cfg_osr_m1 = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 49) == 0);
            tick();
        end
        ovf_clr = 0;

        // Async reset mid-RUN with data pending
        en = 0; tick();
        cfg_osr_m1 = 8'd1; out_ready = 0; en = 1;
        n = 0;
        while (n < 100 && !out_valid) begin tick(); n++; end
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_filt_clr", 32'(filt_clr), 0);
        chk("arst_integ_en", 32'(integ_en), 0);
        chk("arst_dec_stb",  32'(dec_stb),  0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_busy",     32'(busy),     0);
        chk("arst_settled",  32'(settled),  0);
        chk("arst_overflow", 32'(overflow), 0);
        @(negedge CLK);
        en = 0;
        RST = 1'b1;
        m_reset();
        tick();
        chk("post_rst_empty", 32'(out_valid), 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
